sync_fifo_param: RTL and testbench

- Parametrised synchronous FIFO. Next generation of the team's fixed-size buffer.
- Adds configurable width and depth, almost-full/almost-empty thresholds, an occupancy count, write acknowledge and overflow/underflow flags.
- Sits between a producer and a consumer on one clock domain. Output is registered and qualified by valid.

---
 rtl/sync_fifo_param_pkg.sv | 12 +
 rtl/sync_fifo_param_if.sv | 36 +++
 rtl/sync_fifo_param_mem.sv | 27 ++
 rtl/sync_fifo_param_sva.sv | 67 ++++++
 rtl/sync_fifo_param.sv | 109 ++++++++++
 tb/tb_sync_fifo_param.sv | 189 ++++++++++++++++++
 6 files changed

// File: rtl/sync_fifo_param_pkg.sv
// Shared constants and helpers for the parametrised synchronous FIFO.
package sync_fifo_param_pkg;

    localparam int BUS_WIDTH  = 16;
    localparam int FIFO_DEPTH = 8;

    // Occupancy must represent 0..depth inclusive, hence depth+1 states.
    function automatic int clog2_cnt(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/sync_fifo_param_if.sv
// Producer/consumer handshake and status bundle of the synchronous FIFO.
interface sync_fifo_param_if
    import sync_fifo_param_pkg::*;
#(
    parameter int DATA_WIDTH = BUS_WIDTH,
    parameter int DEPTH      = FIFO_DEPTH
);
    localparam int CNT_W = clog2_cnt(DEPTH);

    logic [DATA_WIDTH-1:0] bus_in;
    logic                  wr_en;
    logic                  rd_en;
    logic [DATA_WIDTH-1:0] bus_out;
    logic                  valid;
    logic                  wr_ack;
    logic                  overflow;
    logic                  underflow;
    logic                  full;
    logic                  empty;
    logic                  almost_full;
    logic                  almost_empty;
    logic [CNT_W-1:0]      count;

    modport master (
        output bus_in, wr_en, rd_en,
        input  bus_out, valid, wr_ack, overflow, underflow,
               full, empty, almost_full, almost_empty, count
    );

    modport slave (
        input  bus_in, wr_en, rd_en,
        output bus_out, valid, wr_ack, overflow, underflow,
               full, empty, almost_full, almost_empty, count
    );

endinterface

// File: rtl/sync_fifo_param_mem.sv
// Two-port register array: synchronous write, asynchronous read address.
module fifo_mem_2p
    import sync_fifo_param_pkg::*;
#(
    parameter int DATA_WIDTH = BUS_WIDTH,
    parameter int DEPTH      = FIFO_DEPTH,
    parameter int ADDR_W     = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_W-1:0]     waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [ADDR_W-1:0]     raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/sync_fifo_param_sva.sv
// Protocol checker for sync_fifo_param, bound onto every instance of the top.
module sync_fifo_param_sva
    import sync_fifo_param_pkg::*;
#(
    parameter int DATA_WIDTH = BUS_WIDTH,
    parameter int DEPTH      = FIFO_DEPTH,
    parameter int AF_TH      = DEPTH - 1,
    parameter int AE_TH      = 1,
    parameter int CNT_W      = clog2_cnt(DEPTH)
) (
    input logic                  clk,
    input logic                  rst,
    input logic                  wr_en,
    input logic                  rd_en,
    input logic [DATA_WIDTH-1:0] bus_out,
    input logic                  valid,
    input logic                  wr_ack,
    input logic                  overflow,
    input logic                  underflow,
    input logic                  full,
    input logic                  empty,
    input logic                  almost_full,
    input logic                  almost_empty,
    input logic [CNT_W-1:0]      count
);

    a_reset_values: assert property (@(posedge clk)
        rst |=> (count == '0 && bus_out == '0 && !valid && !wr_ack && !overflow &&
                 !underflow && empty && !full && almost_empty &&
                 almost_full == (AF_TH == 0)));

    a_read_valid: assert property (@(posedge clk) disable iff (rst)
        (rd_en && !empty) |=> valid);

    a_full_empty_excl: assert property (@(posedge clk) !(full && empty));

    a_count_bound: assert property (@(posedge clk) int'(count) <= DEPTH);

    a_overflow: assert property (@(posedge clk) disable iff (rst)
        (wr_en && full && !rd_en) |=> overflow);

    a_almost_empty: assert property (@(posedge clk)
        almost_empty == (int'(count) <= AE_TH));

endmodule

bind sync_fifo_param sync_fifo_param_sva #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .AF_TH      (AF_TH),
    .AE_TH      (AE_TH)
) u_sva (
    .clk          (CLK),
    .rst          (rst),
    .wr_en        (wr_en),
    .rd_en        (rd_en),
    .bus_out      (data_q),
    .valid        (valid_q),
    .wr_ack       (wr_ack_q),
    .overflow     (overflow_q),
    .underflow    (underflow_q),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .count        (count_q)
);

// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO with registered, valid-qualified output and status flags.
module sync_fifo_param
    import sync_fifo_param_pkg::*;
#(
    parameter int DATA_WIDTH = BUS_WIDTH,
    parameter int DEPTH      = FIFO_DEPTH,
    parameter int AF_TH      = DEPTH - 1,
    parameter int AE_TH      = 1
) (
    input logic              CLK,
    input logic              rst,
    sync_fifo_param_if.slave fifo
);

    localparam int CNT_W = clog2_cnt(DEPTH);
    localparam int PTR_W = $clog2(DEPTH);

    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [CNT_W-1:0]      count_q;
    logic [DATA_WIDTH-1:0] data_q;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  valid_q;
    logic                  wr_ack_q;
    logic                  overflow_q;
    logic                  underflow_q;
    logic                  wr_en;
    logic                  rd_en;
    logic                  full;
    logic                  empty;
    logic                  almost_full;
    logic                  almost_empty;
    logic                  wr_acc;
    logic                  rd_acc;
    logic                  mem_we;

    // Explicit wrap so non-power-of-two depths never address past DEPTH-1.
    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign wr_en = fifo.wr_en;
    assign rd_en = fifo.rd_en;

    assign full         = (count_q == CNT_W'(DEPTH));
    assign empty        = (count_q == '0);
    assign almost_full  = (count_q >= CNT_W'(AF_TH));
    assign almost_empty = (count_q <= CNT_W'(AE_TH));

    // A read in the same cycle frees a slot, so a full FIFO still takes the write.
    assign wr_acc = wr_en && (!full || rd_en);
    assign rd_acc = rd_en && !empty;
    assign mem_we = wr_acc && !rst;

    fifo_mem_2p #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .ADDR_W     (PTR_W)
    ) u_mem (
        .clk   (CLK),
        .we    (mem_we),
        .waddr (wr_ptr),
        .wdata (fifo.bus_in),
        .raddr (rd_ptr),
        .rdata (rd_data)
    );

    always_ff @(posedge CLK) begin
        if (rst) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count_q     <= '0;
            data_q      <= '0;
            valid_q     <= 1'b0;
            wr_ack_q    <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= ptr_next(wr_ptr);
            end
            if (rd_acc) begin
                rd_ptr <= ptr_next(rd_ptr);
                data_q <= rd_data;
            end
            unique case ({wr_acc, rd_acc})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
            valid_q     <= rd_acc;
            wr_ack_q    <= wr_acc;
            overflow_q  <= wr_en && !wr_acc;
            underflow_q <= rd_en && !rd_acc;
        end
    end

    assign fifo.bus_out      = data_q;
    assign fifo.valid        = valid_q;
    assign fifo.wr_ack       = wr_ack_q;
    assign fifo.overflow     = overflow_q;
    assign fifo.underflow    = underflow_q;
    assign fifo.full         = full;
    assign fifo.empty        = empty;
    assign fifo.almost_full  = almost_full;
    assign fifo.almost_empty = almost_empty;
    assign fifo.count        = count_q;

endmodule

// File: tb/tb_sync_fifo_param.sv
// Two FIFO instances (DEPTH 8 and 5) share one stimulus stream; each is checked against a queue model.
module tb_sync_fifo_param;
    import sync_fifo_param_pkg::*;

    localparam int DW = BUS_WIDTH;

    logic          CLK = 1'b0;
    logic          rst = 1'b0;
    logic          wr_en = 1'b0;
    logic          rd_en = 1'b0;
    logic [DW-1:0] bus_in = '0;

    int errors = 0;
    int checks = 0;

    always #5 CLK = ~CLK;

    sync_fifo_param_if #(.DATA_WIDTH(DW), .DEPTH(8)) bus8 ();
    sync_fifo_param_if #(.DATA_WIDTH(DW), .DEPTH(5)) bus5 ();

    assign bus8.wr_en  = wr_en;
    assign bus8.rd_en  = rd_en;
    assign bus8.bus_in = bus_in;
    assign bus5.wr_en  = wr_en;
    assign bus5.rd_en  = rd_en;
    assign bus5.bus_in = bus_in;

    sync_fifo_param #(
        .DATA_WIDTH (DW),
        .DEPTH      (8)
    ) u_dut8 (
        .CLK  (CLK),
        .rst  (rst),
        .fifo (bus8.slave)
    );

    sync_fifo_param #(
        .DATA_WIDTH (DW),
        .DEPTH      (5),
        .AF_TH      (3),
        .AE_TH      (2)
    ) u_dut5 (
        .CLK  (CLK),
        .rst  (rst),
        .fifo (bus5.slave)
    );

    // Reference model state, index 0 = DEPTH 8 instance, 1 = DEPTH 5 instance.
    logic [DW-1:0] mq [2][$];
    logic [DW-1:0] e_out [2];
    logic          e_valid [2];
    logic          e_ack [2];
    logic          e_ovf [2];
    logic          e_udf [2];

    function automatic int dep_of(input int k);
        return (k == 0) ? 8 : 5;
    endfunction

    function automatic int af_of(input int k);
        return (k == 0) ? 7 : 3;
    endfunction

    function automatic int ae_of(input int k);
        return (k == 0) ? 1 : 2;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_step(input int k, input logic w, input logic r,
                              input logic [DW-1:0] d, input logic rs);
        int  n;
        logic rd_ok;
        logic wr_ok;
        if (rs) begin
            mq[k].delete();
            e_out[k]   = '0;
            e_valid[k] = 1'b0;
            e_ack[k]   = 1'b0;
            e_ovf[k]   = 1'b0;
            e_udf[k]   = 1'b0;
        end else begin
            n     = mq[k].size();
            rd_ok = r && (n > 0);
            wr_ok = w && ((n < dep_of(k)) || r);
            if (rd_ok) e_out[k] = mq[k].pop_front();
            if (wr_ok) mq[k].push_back(d);
            e_valid[k] = rd_ok;
            e_ack[k]   = wr_ok;
            e_ovf[k]   = w && !wr_ok;
            e_udf[k]   = r && !rd_ok;
        end
    endtask

    task automatic check_inst(input int k);
        logic [DW-1:0] o_out;
        logic o_v, o_ack, o_ovf, o_udf, o_full, o_empty, o_af, o_ae;
        int   o_cnt;
        int   n;
        int   dp;
        string p;
        if (k == 0) begin
            o_out = bus8.bus_out; o_v = bus8.valid; o_ack = bus8.wr_ack;
            o_ovf = bus8.overflow; o_udf = bus8.underflow; o_full = bus8.full;
            o_empty = bus8.empty; o_af = bus8.almost_full; o_ae = bus8.almost_empty;
            o_cnt = int'(bus8.count);
        end else begin
            o_out = bus5.bus_out; o_v = bus5.valid; o_ack = bus5.wr_ack;
            o_ovf = bus5.overflow; o_udf = bus5.underflow; o_full = bus5.full;
            o_empty = bus5.empty; o_af = bus5.almost_full; o_ae = bus5.almost_empty;
            o_cnt = int'(bus5.count);
        end
        n  = mq[k].size();
        dp = dep_of(k);
        p  = $sformatf("D%0d", dp);
        check({p, "_bus_out"},      32'(o_out),   32'(e_out[k]));
        check({p, "_valid"},        32'(o_v),     32'(e_valid[k]));
        check({p, "_wr_ack"},       32'(o_ack),   32'(e_ack[k]));
        check({p, "_overflow"},     32'(o_ovf),   32'(e_ovf[k]));
        check({p, "_underflow"},    32'(o_udf),   32'(e_udf[k]));
        check({p, "_count"},        32'(o_cnt),   32'(n));
        check({p, "_full"},         32'(o_full),  32'(n == dp));
        check({p, "_empty"},        32'(o_empty), 32'(n == 0));
        check({p, "_almost_full"},  32'(o_af),    32'(n >= af_of(k)));
        check({p, "_almost_empty"}, 32'(o_ae),    32'(n <= ae_of(k)));
    endtask

    task automatic cycle(input logic w, input logic r, input logic [DW-1:0] d, input logic rs);
        wr_en  = w;
        rd_en  = r;
        bus_in = d;
        rst    = rs;
        for (int k = 0; k < 2; k++) model_step(k, w, r, d, rs);
        @(posedge CLK);
        #1;
        for (int k = 0; k < 2; k++) check_inst(k);
    endtask

    initial begin
        // Reset and idle
        cycle(1'b0, 1'b0, '0, 1'b1);
        cycle(1'b0, 1'b0, '0, 1'b1);
        cycle(1'b0, 1'b0, '0, 1'b0);

        // Fill 0x0001..0x0008, then a rejected 0xDEAD, then drain past empty
        for (int i = 1; i <= 8; i++) cycle(1'b1, 1'b0, DW'(i), 1'b0);
        cycle(1'b1, 1'b0, 16'hDEAD, 1'b0);
        for (int i = 0; i < 8; i++) cycle(1'b0, 1'b1, '0, 1'b0);
        cycle(1'b0, 1'b1, '0, 1'b0);
        cycle(1'b0, 1'b0, '0, 1'b0);

        // Simultaneous access when full, then drain, then both on empty
        for (int i = 0; i < 8; i++) cycle(1'b1, 1'b0, DW'($urandom), 1'b0);
        cycle(1'b1, 1'b1, 16'h00AA, 1'b0);
        for (int i = 0; i < 8; i++) cycle(1'b0, 1'b1, '0, 1'b0);
        cycle(1'b1, 1'b1, 16'h1234, 1'b0);
        cycle(1'b0, 1'b1, '0, 1'b0);

        // Interleaved 3 writes / 2 reads to exercise pointer wrap
        cycle(1'b0, 1'b0, '0, 1'b1);
        for (int i = 0; i < 20; i++) begin
            if ((i % 5) < 3) cycle(1'b1, 1'b0, DW'($urandom), 1'b0);
            else             cycle(1'b0, 1'b1, '0, 1'b0);
        end

        // Reset mid-operation with a concurrent write that must be dropped
        cycle(1'b0, 1'b0, '0, 1'b1);
        for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, DW'($urandom), 1'b0);
        cycle(1'b1, 1'b0, 16'hBEEF, 1'b1);
        cycle(1'b0, 1'b1, '0, 1'b0);
        cycle(1'b0, 1'b0, '0, 1'b0);

        // Randomized traffic with occasional resets
        for (int i = 0; i < 400; i++) begin
            cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  DW'($urandom), 1'($urandom_range(0, 63) == 0));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
